de_scan: RTL

- Parametrised, registered binary-to-one-hot decoder. Generalises the 2-to-4 decoder to CODE_W inputs and 2**CODE_W outputs.
- Adds a self-timed scan mode that walks the one-hot output across all lines, holding each for DIV clocks. Typical use is multiplexed digit/row select on 7-segment or LED-matrix displays.
- Sits between control logic that supplies a code, and the pad-level select lines.

---
 rtl/de_scan_if.sv | 31 +++
 rtl/de_scan.sv | 90 +++++++++
 2 files changed

// File: rtl/de_scan_if.sv
// ------------------------------------------------------------------
// de_scan_if: code/select bundle between control logic and de_scan.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface de_scan_if #(
  parameter int CODE_W = 2
);
  localparam int OUT_W = 2**CODE_W;

  logic              en;
  logic              mode;
  logic              load;
  logic [CODE_W-1:0] code;
  logic [OUT_W-1:0]  de;
  logic [CODE_W-1:0] idx;
  logic              tick;

  modport master (
    output en, mode, load, code,
    input  de, idx, tick
  );

  modport slave (
    input  en, mode, load, code,
    output de, idx, tick
  );
endinterface

`default_nettype wire

// File: rtl/de_scan.sv
// ------------------------------------------------------------------
// de_scan: registered binary-to-one-hot decoder with self-timed scan.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module de_scan #(
  parameter int CODE_W     = 2,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic      clk,
  input  logic      rst,
  de_scan_if.slave  bus
);

  localparam int OUT_W = 2**CODE_W;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [OUT_W-1:0] DE_POL   = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] idx_q,   idx_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [OUT_W-1:0]  de_q,    de_d;
  logic              tick_q,  tick_d;
  logic              line_on;

  // de is derived from the next idx so it always equals onehot(idx) when active.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = '0;
    tick_d  = 1'b0;
    line_on = 1'b0;

    if (!bus.en) begin
      state_d = ST_IDLE;
    end else if (!bus.mode) begin
      state_d = ST_DECODE;
      line_on = 1'b1;
      if (bus.load) begin
        idx_d = bus.code;
      end
    end else begin
      state_d = ST_SCAN;
      line_on = 1'b1;
      if (state_q != ST_SCAN) begin
        idx_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        idx_d  = idx_q + 1'b1;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    de_d = (line_on ? (OUT_W'(1) << idx_d) : {OUT_W{1'b0}}) ^ DE_POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      de_q    <= DE_POL;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      de_q    <= de_d;
    end
  end

  assign bus.de   = de_q;
  assign bus.idx  = idx_q;
  assign bus.tick = tick_q;

endmodule

`default_nettype wire
